spi_fifo_ctrl: RTL
==================

SPI_FIFO_CTRL -- requirements
Module: spi_fifo_ctrl

Interface
REQ-001 Parameter: DEPTH, default 8, entries per FIFO; power of two, 2..64.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 wr  in  1  push {wrFast, wrNoRx, wdata} into TX FIFO.
REQ-005 wdata  in  32  word to transmit; slow mode uses only [7:0].
REQ-006 wrFast  in  1  per-entry mode: 1 = fast 32-bit word, 0 = slow byte.
REQ-007 wrNoRx  in  1  per-entry flag: 1 = discard received data.
REQ-008 rd  in  1  pop RX FIFO head.
REQ-009 rdata  out  32  RX FIFO head, first-word-fall-through.
REQ-010 txFull, txEmpty, rxFull, rxEmpty  out  1 each  FIFO status.
REQ-011 txLevel, rxLevel  out  log2(DEPTH)+1  entry counts.
REQ-012 txOvf  out  1  sticky: a push to a full TX FIFO was dropped; cleared by clrOvf.
REQ-013 clrOvf  in  1  clears txOvf.
REQ-014 busy  out  1  high when FSM is not IDLE or TX FIFO is non-empty.
REQ-015 spiStart  out  1  one-cycle start pulse to the SPI transceiver.
REQ-016 spiFast  out  1  mode of the current transfer, held stable from spiStart until completion.
REQ-017 spiDataTx  out  32  word to the transceiver, stable while spiStart is high.
REQ-018 spiDataRx  in  32  received data from the transceiver (byte zero-extended in slow mode).
REQ-019 spiRdy  in  1  transceiver idle or done; drops the cycle after spiStart.

Function
REQ-020 TX FIFO SHALL be 34 bits wide ({fast, noRx, data}); RX FIFO SHALL be 32 bits wide; both DEPTH deep with wrapping pointers.
REQ-021 Status flags and levels SHALL be registered and consistent with FIFO contents in every cycle.
REQ-022 A push to a full TX FIFO SHALL be dropped and set txOvf; a simultaneous clrOvf SHALL lose to the set.
REQ-023 rd while RX FIFO is empty SHALL be ignored, leaving rdata unchanged.
REQ-024 rdata SHALL show the RX head whenever rxEmpty=0.
REQ-025 FSM states are IDLE, START, WAIT.
REQ-026 IDLE -> START when txEmpty=0, spiRdy=1, and (head noRx=1 or rxFull=0); the TX head SHALL be popped and latched into spiDataTx, spiFast and an internal noRx register on that edge.
REQ-027 In START, spiStart=1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-028 In WAIT, spiRdy=1 SHALL push spiDataRx into the RX FIFO unless noRx=1, and the FSM SHALL go to IDLE on the same edge.
REQ-029 A wr sampled at edge k into an empty TX FIFO while idle SHALL raise spiStart in the cycle after edge k+1.
REQ-030 Back-to-back entries SHALL be separated by exactly one IDLE cycle.
REQ-031 Space is reserved at launch time, so an RX push from WAIT SHALL never overflow.
REQ-032 A simultaneous push and pop on the same FIFO SHALL leave its level unchanged and apply both.
REQ-033 A user rd in the same cycle as an FSM RX push into an empty FIFO SHALL be ignored.
REQ-034 Level arithmetic SHALL be unsigned; pointers SHALL wrap modulo DEPTH.

Reset
REQ-035 While rst=1 and on the first cycle after: FSM=IDLE, both FIFOs empty (levels 0, txEmpty=rxEmpty=1, txFull=rxFull=0), txOvf=0, spiStart=0, spiFast=0, spiDataTx=0, busy=0, rdata=0.
REQ-036 rst during START or WAIT SHALL abort the transfer and discard its RX data.
REQ-037 After reset, no new spiStart SHALL issue until spiRdy=1 is observed in IDLE, so a transceiver still finishing a transfer is never restarted.

Verification
REQ-038 Push 0xA5A5_1234 (fast=1, noRx=0) with a transceiver model returning 0xDEAD_BEEF after 96 cycles -> spiStart 2 edges after wr; rxLevel=1; rdata=0xDEAD_BEEF; busy falls.
REQ-039 Push 0xFF (fast=0) with the model returning byte 0x3C after 512 cycles -> spiFast=0 throughout; rdata=0x0000_003C.
REQ-040 Push DEPTH+1 words with spiRdy held 0 -> txFull=1, txLevel=DEPTH, txOvf=1; clrOvf -> txOvf=0.
REQ-041 Fill RX FIFO to DEPTH with 2 TX entries pending (noRx=0) -> no spiStart; one rd -> exactly one launch.
REQ-042 Assert rst in mid-WAIT with spiRdy=0 -> all outputs at reset values; no spiStart until the model raises spiRdy.
REQ-043 Queue 4 words with noRx=1 -> 4 spiStart pulses, each separated from the previous done by one IDLE cycle; rxLevel remains 0.

Source files
------------

// File: rtl/spi_fifo_ctrl.sv
// SPI transfer sequencer: 34-bit TX FIFO of {fast, noRx, data} entries feeding an external transceiver,
// with a 32-bit first-word-fall-through RX FIFO collecting the received words.
module spi_fifo_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [31:0]            wdata,
  input  logic                   wrFast,
  input  logic                   wrNoRx,
  input  logic                   rd,
  output logic [31:0]            rdata,
  output logic                   txFull,
  output logic                   txEmpty,
  output logic                   rxFull,
  output logic                   rxEmpty,
  output logic [$clog2(DEPTH):0] txLevel,
  output logic [$clog2(DEPTH):0] rxLevel,
  output logic                   txOvf,
  input  logic                   clrOvf,
  output logic                   busy,
  output logic                   spiStart,
  output logic                   spiFast,
  output logic [31:0]            spiDataTx,
  input  logic [31:0]            spiDataRx,
  input  logic                   spiRdy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  // IDLE: wait for a TX entry, idle transceiver and RX room | START: spiStart pulse | WAIT: await spiRdy
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;
  state_t state_q, state_d;

  logic [33:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [AW:0]   tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic          tx_full_q, tx_empty_q, rx_full_q, rx_empty_q;
  logic          ovf_q, no_rx_q, fast_q;
  logic [31:0]   data_tx_q;
  logic [33:0]   tx_head;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  assign tx_head = tx_mem[tx_rptr_q];
  assign tx_push = wr && !tx_full_q;
  assign rx_pop  = rd && !rx_empty_q;

  // An entry that returns data only launches when the RX FIFO has a free slot for it.
  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty_q && spiRdy && (tx_head[32] || !rx_full_q)) begin
          tx_pop  = 1'b1;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (spiRdy) begin
          rx_push = !no_rx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);
  assign rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= {wrFast, wrNoRx, wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_level_q <= '0;
      tx_full_q  <= 1'b0;
      tx_empty_q <= 1'b1;
      rx_full_q  <= 1'b0;
      rx_empty_q <= 1'b1;
      ovf_q      <= 1'b0;
      no_rx_q    <= 1'b0;
      fast_q     <= 1'b0;
      data_tx_q  <= '0;
      for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop) begin
        tx_rptr_q <= tx_rptr_q + 1'b1;
        fast_q    <= tx_head[33];
        no_rx_q   <= tx_head[32];
        data_tx_q <= tx_head[31:0];
      end
      if (rx_push) begin
        rx_mem[rx_wptr_q] <= spiDataRx;
        rx_wptr_q         <= rx_wptr_q + 1'b1;
      end
      if (rx_pop) rx_rptr_q <= rx_rptr_q + 1'b1;
      tx_level_q <= tx_level_d;
      tx_full_q  <= (tx_level_d == FULL_LVL);
      tx_empty_q <= (tx_level_d == '0);
      rx_level_q <= rx_level_d;
      rx_full_q  <= (rx_level_d == FULL_LVL);
      rx_empty_q <= (rx_level_d == '0);
      if (wr && tx_full_q) ovf_q <= 1'b1;
      else if (clrOvf)     ovf_q <= 1'b0;
    end
  end

  assign rdata     = rx_mem[rx_rptr_q];
  assign txFull    = tx_full_q;
  assign txEmpty   = tx_empty_q;
  assign rxFull    = rx_full_q;
  assign rxEmpty   = rx_empty_q;
  assign txLevel   = tx_level_q;
  assign rxLevel   = rx_level_q;
  assign txOvf     = ovf_q;
  assign busy      = (state_q != IDLE) || !tx_empty_q;
  assign spiStart  = (state_q == START);
  assign spiFast   = fast_q;
  assign spiDataTx = data_tx_q;

endmodule
